// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame edge indices and default timing.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StSend,
        StAck,
        StWait
    } ps2_tx_state_t;

    // Falling-edge indices within a host-to-device frame (edges 1..8 carry data bits)
    localparam int unsigned PARITY_EDGE = 9;
    localparam int unsigned STOP_EDGE   = 10;

    localparam int unsigned PS2_CLK_HZ         = 200_000_000;
    localparam int unsigned PS2_INHIBIT_CYCLES = 20_000;
    localparam int unsigned PS2_REQ_CYCLES     = 200;
    localparam int unsigned PS2_FILTER_LEN     = 8;
    localparam int unsigned PS2_TIMEOUT_CYCLES = 3_000_000;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// One PS/2 line: 2-flop synchronizer, FILTER_LEN-sample glitch filter, registered falling-edge pulse.
module ps2_line_sync
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = PS2_FILTER_LEN
) (
    input  logic clk200m,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fall
);

    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             fall_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts consecutive synchronized samples that disagree with the accepted level
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk200m or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= pin;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            fall_q  <= level_q & ~level_d;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-drain clock/data enables).
// Optional transfer watchdog built when PS2_HOST_TX_TIMEOUT_EN is defined.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ         = PS2_CLK_HZ,
    parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int unsigned REQ_CYCLES     = PS2_REQ_CYCLES,
    parameter int unsigned FILTER_LEN     = PS2_FILTER_LEN,
    parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic       clk200m,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit,
    output logic       done,
    output logic       err
);

    localparam int unsigned PHASE_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int unsigned unused_clk_hz = CLK_HZ;

    ps2_tx_state_t    state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [3:0]       edge_q, edge_d, edge_next;
    logic [7:0]       byte_q, byte_d;
    logic             par_q, par_d;
    logic             nack_q, nack_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             ready_q, ready_d;
    logic             inhibit_q, inhibit_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             clk_level, clk_fall;
    logic             data_level, data_fall_unused;
    logic             timeout;

    ps2_line_sync #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_sync (
        .clk200m (clk200m),
        .rst     (rst),
        .pin     (ps2_clk_in),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    ps2_line_sync #(
        .FILTER_LEN (FILTER_LEN)
    ) u_data_sync (
        .clk200m (clk200m),
        .rst     (rst),
        .pin     (ps2_data_in),
        .level   (data_level),
        .fall    (data_fall_unused)
    );

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            wd_run;

    // Runs from clock release until the block returns to idle
    assign wd_run  = state_q inside {StSend, StAck, StWait};
    assign wd_d    = wd_run ? wd_q + 1'b1 : '0;
    assign timeout = wd_run && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk200m or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    assign edge_next = edge_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        edge_d    = edge_q;
        byte_d    = byte_q;
        par_d     = par_q;
        nack_d    = nack_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tx_valid && ready_q) begin
                    byte_d    = tx_data;
                    par_d     = odd_parity(tx_data);
                    nack_d    = 1'b0;
                    phase_d   = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                if (phase_q == PHASE_W'(INHIBIT_CYCLES - 1)) begin
                    phase_d   = '0;
                    data_oe_d = 1'b1;
                    state_d   = StReq;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StReq: begin
                if (phase_q == PHASE_W'(REQ_CYCLES - 1)) begin
                    phase_d  = '0;
                    clk_oe_d = 1'b0;
                    edge_d   = '0;
                    state_d  = StSend;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StSend: begin
                if (clk_fall) begin
                    edge_d = edge_next;
                    if (edge_next == 4'(STOP_EDGE)) begin
                        data_oe_d = 1'b0;
                        state_d   = StAck;
                    end else if (edge_next == 4'(PARITY_EDGE)) begin
                        data_oe_d = ~par_q;
                    end else begin
                        data_oe_d = ~byte_q[edge_q[2:0]];
                    end
                end
            end
            StAck: begin
                if (clk_fall) begin
                    nack_d  = data_level;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (clk_level && data_level) begin
                    done_d  = 1'b1;
                    err_d   = nack_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Watchdog overrides any edge seen in the same cycle
        if (timeout) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            err_d     = 1'b1;
            state_d   = StIdle;
        end

        ready_d   = (state_d == StIdle) && !done_d;
        inhibit_d = (state_d != StIdle);
    end

    always_ff @(posedge clk200m or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            edge_q    <= '0;
            byte_q    <= '0;
            par_q     <= 1'b0;
            nack_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            inhibit_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            edge_q    <= edge_d;
            byte_q    <= byte_d;
            par_q     <= par_d;
            nack_q    <= nack_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ready_q   <= ready_d;
            inhibit_q <= inhibit_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign tx_ready    = ready_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign rx_inhibit  = inhibit_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model (scaled-down timing).
module tb_ps2_host_tx;

    localparam int INH = 100;
    localparam int REQ = 10;
    localparam int FL  = 8;
    localparam int TMO = 3000;
    localparam int HP  = 40;

    logic       clk200m = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       rx_inhibit, done, err;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    int tests = 0;
    int failures = 0;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk200m = ~clk200m;

    ps2_host_tx #(
        .CLK_HZ         (200_000_000),
        .INHIBIT_CYCLES (INH),
        .REQ_CYCLES     (REQ),
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk200m     (clk200m),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .rx_inhibit  (rx_inhibit),
        .done        (done),
        .err         (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk200m);
        #1;
    endtask

    task automatic start_frame(input logic [7:0] b, output int inh, output int req);
        tx_data  = b;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        check_eq("accept_clk_oe", ps2_clk_oe, 1);
        check_eq("accept_ready", tx_ready, 0);
        check_eq("accept_inhibit", rx_inhibit, 1);
        inh = 0;
        while (!ps2_data_oe && inh < INH + 50) begin
            step(1);
            inh++;
        end
        req = 0;
        while (ps2_clk_oe && req < REQ + 50) begin
            step(1);
            req++;
        end
    endtask

    // Device clocks the frame, sampling data on each rising edge, then answers ACK/NACK
    task automatic dev_frame(input logic ack, input int glitch_at, input int abort_at,
                             output logic [9:0] bits, output int lat);
        int n;
        bits = '0;
        lat  = 0;
        n    = 0;
        while (ps2_clk_oe && n < 1000) begin
            step(1);
            n++;
        end
        step(HP);
        for (int i = 1; i <= 11; i++) begin
            dev_clk = 1'b0;
            for (int k = 1; k <= HP; k++) begin
                step(1);
                if (i == 1 && lat == 0 && ps2_data_oe !== 1'b1) lat = k;
            end
            if (i == abort_at) return;
            dev_clk = 1'b1;
            if (i <= 10) bits[i-1] = ps2_data_in;
            if (i == 10) dev_data = ack ? 1'b0 : 1'b1;
            if (i == 11) begin
                dev_data = 1'b1;
                return;
            end
            if (i == glitch_at) begin
                step(10);
                dev_clk = 1'b0;
                step(4);
                dev_clk = 1'b1;
                step(HP - 14);
            end else begin
                step(HP);
            end
        end
    endtask

    task automatic finish_frame(input logic exp_err);
        int n;
        n = 0;
        while (!done && n < 200) begin
            step(1);
            n++;
        end
        check_eq("done_seen", done, 1);
        check_eq("done_err", err, exp_err);
        check_eq("done_clk_rel", ps2_clk_oe, 0);
        check_eq("done_data_rel", ps2_data_oe, 0);
        check_eq("done_ready_low", tx_ready, 0);
        step(1);
        check_eq("done_one_cycle", done, 0);
        check_eq("ready_after_done", tx_ready, 1);
        check_eq("inhibit_after_done", rx_inhibit, 0);
    endtask

    initial begin
        logic [9:0] bits;
        int inh, req, lat, n;

        #1 rst = 1'b1;
        #1;
        check_eq("rst_ready", tx_ready, 1);
        check_eq("rst_clk_oe", ps2_clk_oe, 0);
        check_eq("rst_data_oe", ps2_data_oe, 0);
        check_eq("rst_inhibit", rx_inhibit, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        step(3);
        rst = 1'b0;
        step(5);

        // 0xF4 with ACK
        start_frame(8'hF4, inh, req);
        dev_frame(1'b1, 0, 0, bits, lat);
        check_eq("f4_frame", bits, 10'h2F4);
        finish_frame(1'b0);
        step(20);

        // 0xED with ACK, exact phase lengths and edge-to-bit latency
        start_frame(8'hED, inh, req);
        check_eq("ed_inhibit_len", inh, INH);
        check_eq("ed_req_len", req, REQ);
        dev_frame(1'b1, 0, 0, bits, lat);
        check_eq("ed_frame", bits, 10'h3ED);
        check_eq("ed_edge_latency", lat, 2 + FL + 1);
        finish_frame(1'b0);
        step(20);

        // 0xA5 with NACK, clock glitch and ignored request while busy
        start_frame(8'hA5, inh, req);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        step(5);
        tx_valid = 1'b0;
        dev_frame(1'b0, 3, 0, bits, lat);
        check_eq("a5_frame_glitch", bits, 10'h3A5);
        finish_frame(1'b1);
        step(300);
        check_eq("no_second_frame", ps2_clk_oe, 0);
        check_eq("idle_ready", tx_ready, 1);

        // Silent device
        start_frame(8'h12, inh, req);
        n = 0;
        while (!done && n < TMO + 100) begin
            step(1);
            n++;
        end
`ifdef PS2_HOST_TX_TIMEOUT_EN
        check_eq("timeout_cycles", n, TMO);
        check_eq("timeout_err", err, 1);
        check_eq("timeout_clk_rel", ps2_clk_oe, 0);
        check_eq("timeout_data_rel", ps2_data_oe, 0);
        step(1);
        check_eq("timeout_ready", tx_ready, 1);
`else
        check_eq("no_timeout_done", done, 0);
        check_eq("no_timeout_ready", tx_ready, 0);
        check_eq("no_timeout_inhibit", rx_inhibit, 1);
        rst = 1'b1;
        #1;
        check_eq("stuck_rst_ready", tx_ready, 1);
        step(2);
        rst = 1'b0;
`endif
        step(20);

        // Reset after edge 5 (bit 4 of 0xE7 is 0, so data_oe is held high)
        start_frame(8'hE7, inh, req);
        dev_frame(1'b1, 0, 5, bits, lat);
        check_eq("pre_rst_data_oe", ps2_data_oe, 1);
        rst = 1'b1;
        #1;
        check_eq("midrst_clk_oe", ps2_clk_oe, 0);
        check_eq("midrst_data_oe", ps2_data_oe, 0);
        check_eq("midrst_ready", tx_ready, 1);
        check_eq("midrst_inhibit", rx_inhibit, 0);
        step(3);
        dev_clk = 1'b1;
        rst = 1'b0;
        step(30);

        start_frame(8'hF4, inh, req);
        dev_frame(1'b1, 0, 0, bits, lat);
        check_eq("f4_after_rst_frame", bits, 10'h2F4);
        finish_frame(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
